func_render: RTL and testbench
==============================

Name: func_render

Overview:
- Pixel-colour stage directly downstream of the maths-demo function blocks (circle, etc.).
- Takes the 1-bit function result `r` and the display signals that were presented alongside the coordinates fed to the function. Delays those display signals to match the function latency.
- Overlays axes and grid, and outputs registered 4-bit RGB plus aligned sync and data-enable.
- Measures per-frame "area": the count of active pixels where `r`=1.

Parameters:
- CORDW, 8, signed coordinate width (bits); must match the function block.
- LAT, 4, function latency in cycles from x/y to r; LAT>=1.
- GRIDW, 4, grid spacing is 2^GRIDW pixels; 1<=GRIDW<CORDW.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- x  in  CORDW  signed x coordinate, same cycle it is presented to the function
- y  in  CORDW  signed y coordinate, same cycle
- de  in  1  data enable, same cycle as x/y
- hsync  in  1  horizontal sync, same cycle as x/y
- vsync  in  1  vertical sync, same cycle as x/y
- frame  in  1  start-of-frame pulse (in blanking), same cycle as x/y
- r  in  1  function result, valid LAT cycles after the matching x/y
- paint_r  out  4  red
- paint_g  out  4  green
- paint_b  out  4  blue
- de_o  out  1  aligned data enable
- hsync_o  out  1  aligned hsync
- vsync_o  out  1  aligned vsync
- area  out  2*CORDW+1  previous frame's r-pixel count
- area_valid  out  1  one-cycle pulse when area updates

Behaviour:
- Reset: async assert clears every delay stage, all RGB, de_o, hsync_o, vsync_o, area, area_valid and the accumulator to 0 immediately. Clocking resumes on the first edge after deassert; no stale data emerges, since delay stages hold zeros.
- Stage 0 (combinational on inputs):
  - axis = (x==0) | (y==0)
  - grid = (x[GRIDW-1:0]==0) | (y[GRIDW-1:0]==0)
- Delay line: LAT registered stages carry {axis, grid, de, hsync, vsync, frame}. The stage-LAT outputs are aligned with input r.
- Colour select at stage LAT, priority high to low:
  - aligned de=0 -> 0,0,0
  - axis -> C,C,C
  - r=1 -> F,8,0
  - grid -> 3,3,3
  - else -> 0,0,0
- Output register: RGB, de_o, hsync_o and vsync_o are registered. Total latency from x/y/de/sync inputs to outputs = LAT+1 cycles. Latency from r to RGB = 1 cycle.
- Area accumulator, width 2*CORDW+1, uses aligned signals at stage LAT:
  - Increments when aligned de & r.
  - Saturates at 2^(2*CORDW+1)-1 (all ones); no wrap.
- Frame boundary, on aligned frame=1:
  - area <= accumulator value before this cycle's increment.
  - area_valid <= 1 for exactly one cycle, appearing with the same LAT+1 latency as the outputs.
  - Accumulator <= (aligned de & r) ? 1 : 0.
- Otherwise area_valid=0 and area holds.
- First frame after reset: area reports the pixels counted since reset (a partial frame). Consumers discard the first area_valid.
- Back-to-back frame pulses: each produces its own area_valid; the second reports the pixels counted between them (0 if adjacent).
- r is sampled every cycle regardless of de; only de-qualified r affects colour or count.

Test Plan:
- LAT=4, CORDW=8, GRIDW=4. Drive x=0, y=5, de=1 at cycle T, r=1 at T+4 -> at T+5 RGB=C,C,C and de_o=1 (axis beats function).
- x=3, y=7, de=1 at T, r=1 at T+4 -> F,8,0 at T+5. Same with r=0 -> 0,0,0. With x=16, y=7, r=0 -> 3,3,3.
- de=0, x=3, y=3, r=1 -> RGB 0,0,0. Also check hsync and vsync toggles appear on hsync_o/vsync_o exactly 5 cycles later.
- Frame with 100 pixels at de=1 and r=1 (plus 50 at de=0 with r=1), then frame pulse at F -> area=100 and area_valid=1 only at F+5. Next empty frame -> area=0.
- Assert rst asynchronously mid-line with non-zero outputs -> all outputs 0 before the next clock edge. After release, the first 5 cycles output 0 regardless of inputs, and area=0.
- Force the accumulator near the top (CORDW=4: feed 600 r-pixels) -> area=511 saturated, no wrap.

Source files
------------

// File: rtl/func_render.sv
// Pixel-colour stage for the maths-demo function blocks: aligns display timing with
// the function result, overlays axes and grid, and measures the per-frame r-pixel area.
module func_render #(
    parameter int CORDW = 8,
    parameter int LAT   = 4,
    parameter int GRIDW = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    de,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    frame,
    input  logic                    r,
    output logic [3:0]              paint_r,
    output logic [3:0]              paint_g,
    output logic [3:0]              paint_b,
    output logic                    de_o,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic [2*CORDW:0]        area,
    output logic                    area_valid
);
    localparam int AW = 2*CORDW + 1;
    localparam logic [AW-1:0] ACC_MAX = '1;

    typedef struct packed {
        logic axis;
        logic grid;
        logic de;
        logic hsync;
        logic vsync;
        logic frame;
    } stage_t;

    stage_t            stage0;
    stage_t [LAT-1:0]  pipe_q, pipe_d;
    stage_t            al;
    logic              hit;

    logic [11:0]       rgb_q, rgb_d;
    logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [AW-1:0]     acc_q, acc_d, area_q, area_d;
    logic              area_valid_q, area_valid_d;

    always_comb begin
        stage0.axis  = (x == '0) || (y == '0);
        stage0.grid  = (x[GRIDW-1:0] == '0) || (y[GRIDW-1:0] == '0);
        stage0.de    = de;
        stage0.hsync = hsync;
        stage0.vsync = vsync;
        stage0.frame = frame;
    end

    always_comb begin
        pipe_d[0] = stage0;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // The last delay stage lines up with the function result on r.
    assign al  = pipe_q[LAT-1];
    assign hit = al.de & r;

    always_comb begin
        rgb_d = 12'h000;
        if (!al.de)        rgb_d = 12'h000;
        else if (al.axis)  rgb_d = 12'hCCC;
        else if (r)        rgb_d = 12'hF80;
        else if (al.grid)  rgb_d = 12'h333;
        de_d = al.de;
        hs_d = al.hsync;
        vs_d = al.vsync;
    end

    // A frame pulse reports the total before this cycle's pixel, which starts the new count.
    always_comb begin
        area_d       = area_q;
        area_valid_d = 1'b0;
        acc_d        = acc_q;
        if (al.frame) begin
            area_d       = acc_q;
            area_valid_d = 1'b1;
            acc_d        = hit ? AW'(1) : '0;
        end else if (hit && acc_q != ACC_MAX) begin
            acc_d = acc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q       <= '0;
            rgb_q        <= '0;
            de_q         <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            acc_q        <= '0;
            area_q       <= '0;
            area_valid_q <= 1'b0;
        end else begin
            pipe_q       <= pipe_d;
            rgb_q        <= rgb_d;
            de_q         <= de_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            acc_q        <= acc_d;
            area_q       <= area_d;
            area_valid_q <= area_valid_d;
        end
    end

    assign paint_r    = rgb_q[11:8];
    assign paint_g    = rgb_q[7:4];
    assign paint_b    = rgb_q[3:0];
    assign de_o       = de_q;
    assign hsync_o    = hs_q;
    assign vsync_o    = vs_q;
    assign area       = area_q;
    assign area_valid = area_valid_q;
endmodule

// File: tb/tb_func_render.sv
// Scoreboard bench for func_render: a reference model predicts each output cycle,
// plus directed checks for frame area, async reset and accumulator saturation.
module tb_func_render;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance, CORDW=8
    logic signed [7:0] x, y;
    logic de, hsync, vsync, frame, r;
    logic [3:0] paint_r, paint_g, paint_b;
    logic de_o, hsync_o, vsync_o, area_valid;
    logic [16:0] area;

    // small instance for saturation, CORDW=4
    logic signed [3:0] x2, y2;
    logic de2, hsync2, vsync2, frame2, r2;
    logic [3:0] paint_r2, paint_g2, paint_b2;
    logic de_o2, hsync_o2, vsync_o2, area_valid2;
    logic [8:0] area2;

    func_render #(.CORDW(8), .LAT(LAT), .GRIDW(4)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
        .frame(frame), .r(r), .paint_r(paint_r), .paint_g(paint_g), .paint_b(paint_b),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .area(area), .area_valid(area_valid)
    );

    func_render #(.CORDW(4), .LAT(LAT), .GRIDW(2)) dut_small (
        .clk(clk), .rst(rst), .x(x2), .y(y2), .de(de2), .hsync(hsync2), .vsync(vsync2),
        .frame(frame2), .r(r2), .paint_r(paint_r2), .paint_g(paint_g2), .paint_b(paint_b2),
        .de_o(de_o2), .hsync_o(hsync_o2), .vsync_o(vsync_o2), .area(area2), .area_valid(area_valid2)
    );

    typedef struct {
        string       tag;
        logic [15:0] vec;
        logic [16:0] area;
    } sb_t;

    int checks = 0;
    int errors = 0;
    sb_t         sb[$];
    logic [5:0]  mq[$];
    logic        rq[$];
    logic [16:0] acc_m;
    logic [16:0] area_m;
    int          txn = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rq.delete();
        sb.delete();
        for (int i = 0; i < LAT; i++) begin
            mq.push_back(6'b0);
            rq.push_back(1'b0);
        end
        acc_m  = '0;
        area_m = '0;
    endtask

    // Drive one pixel (its r is presented LAT cycles later), predict the output cycle,
    // then compare it after the clock edge.
    task automatic step(input int xi, input int yi, input bit dei, input bit hsi, input bit vsi,
                        input bit fri, input bit rfi, input string tag);
        logic [7:0]  xv, yv;
        logic [5:0]  al;
        logic        rr, inc;
        logic [11:0] rgb;
        logic        av;
        sb_t         e, got;
        xv = xi[7:0];
        yv = yi[7:0];
        x = xv; y = yv; de = dei; hsync = hsi; vsync = vsi; frame = fri;
        rq.push_back(rfi);
        rr = rq.pop_front();
        r  = rr;
        mq.push_back({(xv == 8'd0) || (yv == 8'd0), (xv[3:0] == 4'd0) || (yv[3:0] == 4'd0),
                      dei, hsi, vsi, fri});
        al = mq.pop_front();
        if (!al[3])      rgb = 12'h000;
        else if (al[5])  rgb = 12'hCCC;
        else if (rr)     rgb = 12'hF80;
        else if (al[4])  rgb = 12'h333;
        else             rgb = 12'h000;
        inc = al[3] & rr;
        av  = 1'b0;
        if (al[0]) begin
            area_m = acc_m;
            av     = 1'b1;
            acc_m  = inc ? 17'd1 : 17'd0;
        end else if (inc && acc_m != 17'h1FFFF) begin
            acc_m = acc_m + 17'd1;
        end
        e.tag  = tag;
        e.vec  = {rgb, al[3], al[2], al[1], av};
        e.area = area_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        txn++;
        check_val({got.tag, "_out"}, {16'h0, paint_r, paint_g, paint_b, de_o, hsync_o, vsync_o, area_valid},
                  {16'h0, got.vec});
        check_val({got.tag, "_area"}, {15'h0, area}, {15'h0, got.area});
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, tag);
    endtask

    // Issue a frame pulse, then wait (bounded) for area_valid and check latency and value.
    task automatic frame_and_check(input logic [16:0] exp_area, input string tag);
        int n;
        bit seen;
        step(1, 1, 0, 0, 0, 1, 0, tag);
        n = 0;
        seen = 0;
        while (!seen && n < 12) begin
            step(1, 1, 0, 0, 0, 0, 0, tag);
            n++;
            if (area_valid) seen = 1;
        end
        check_val({tag, "_lat"}, n, LAT);
        check_val({tag, "_val"}, {15'h0, area}, {15'h0, exp_area});
        $display("txn %0d %s area=%0d after %0d cycles", txn, tag, area, n);
    endtask

    initial begin
        rst = 1'b1;
        x = '0; y = '0; de = 0; hsync = 0; vsync = 0; frame = 0; r = 0;
        x2 = '0; y2 = '0; de2 = 0; hsync2 = 0; vsync2 = 0; frame2 = 0; r2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_out", {paint_r, paint_g, paint_b, de_o, hsync_o, vsync_o, area_valid}, 16'h0);
        check_val("reset_area", {15'h0, area}, 32'h0);
        #2 rst = 1'b0;

        // Directed colour cases, each pixel's r arrives LAT cycles later.
        step(0, 5, 1, 0, 0, 0, 1, "axis");
        step(3, 7, 1, 0, 0, 0, 1, "func");
        step(3, 7, 1, 0, 0, 0, 0, "blank");
        step(16, 7, 1, 0, 0, 0, 0, "grid");
        step(3, 3, 0, 0, 0, 0, 1, "de_off");
        step(3, 3, 0, 1, 0, 0, 1, "hs_on");
        step(3, 3, 0, 1, 1, 0, 0, "vs_on");
        step(3, 3, 0, 0, 1, 0, 0, "hs_off");
        step(3, 3, 0, 0, 0, 0, 0, "vs_off");
        idle(5, "flush");
        $display("txn %0d directed colour and sync cases done", txn);

        // 100 counted pixels plus 50 blanked ones with r=1.
        frame_and_check(17'd2, "first_frame");
        for (int i = 0; i < 100; i++) step(1 + (i % 60), 3, 1, 0, 0, 0, 1, "count_de");
        for (int i = 0; i < 50; i++)  step(1 + i, 3, 0, 0, 0, 0, 1, "count_blank");
        frame_and_check(17'd100, "frame100");
        idle(7, "empty");
        frame_and_check(17'd0, "frame_empty");

        // Adjacent frame pulses: the second reports zero.
        step(1, 1, 1, 0, 0, 0, 1, "pre_b2b");
        step(1, 1, 0, 0, 0, 1, 0, "b2b_a");
        step(1, 1, 0, 0, 0, 1, 0, "b2b_b");
        idle(6, "b2b_flush");

        // Async reset mid-line with non-zero outputs.
        for (int i = 0; i < 10; i++) step(3, 7, 1, 1, 1, 0, 1, "pre_rst");
        check_val("pre_rst_red", {28'h0, paint_r}, 32'hF);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_out", {paint_r, paint_g, paint_b, de_o, hsync_o, vsync_o, area_valid}, 16'h0);
        check_val("async_rst_area", {15'h0, area}, 32'h0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 8; i++) step(0, i, 1, 1, 1, 0, 1, "post_rst");
        check_val("post_rst_area", {15'h0, area}, 32'h0);

        // Randomised traffic; the scoreboard checks every output cycle.
        for (int i = 0; i < 300; i++)
            step($urandom_range(40) - 20, $urandom_range(40) - 20, 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(40) == 0),
                 1'($urandom_range(1)), "rand");
        idle(6, "rand_flush");
        $display("txn %0d random traffic done", txn);

        // Saturation on the 4-bit instance: 600 counted pixels must report 511.
        begin
            int  n;
            bit  seen;
            @(posedge clk); #1;
            frame2 = 1; de2 = 0; r2 = 0;
            @(posedge clk); #1;
            frame2 = 0; de2 = 1; r2 = 1; x2 = 4'sd1; y2 = 4'sd1;
            repeat (600) @(posedge clk);
            #1;
            frame2 = 1; de2 = 0;
            @(posedge clk); #1;
            frame2 = 0; r2 = 0;
            n = 0;
            seen = 0;
            while (!seen && n < 20) begin
                if (area_valid2 && area2 != 9'd0) seen = 1;
                else begin
                    @(posedge clk); #1;
                    n++;
                end
            end
            check_val("sat_seen", {31'h0, seen}, 32'h1);
            check_val("sat_area", {23'h0, area2}, 32'd511);
            $display("txn %0d saturation area=%0d", txn, area2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
